// File: rtl/exec_stage_md.sv
// EX stage: forwarding, ALU, branch/jump resolution, iterative RV32M mul/div and EX/MEM registers.
// Define EXEC_MD_FAST_MUL_EN to execute MUL* in one cycle on a combinational multiplier.
//
// state | meaning
// IDLE  | no M op in flight; an iterative M op at the input issues here
// BUSY  | one shift-add / restoring-subtract step per clk, count runs down to 0
// DONE  | result ready in acc; waits for EX/MEM to accept it
module exec_stage_md #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [RA_W-1:0] rs1_num,
    input  logic [RA_W-1:0] rs2_num,
    input  logic [RA_W-1:0] rd_num,
    input  logic [1:0]      fwd1_sel,
    input  logic [1:0]      fwd2_sel,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    input  logic            alu_src,
    input  logic [3:0]      alu_ctrl,
    input  logic            md_op,
    input  logic [2:0]      md_funct,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic [2:0]      br_funct,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic            mem_read,
    input  logic [1:0]      result_src,
    output logic            stall,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic            out_valid,
    output logic            out_reg_write,
    output logic            out_mem_write,
    output logic            out_mem_read,
    output logic [1:0]      out_result_src,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_write_data,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [RA_W-1:0] out_rd_num
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   md_opnd;
    logic [XLEN-1:0]   md_dividend;
    logic [2:0]        md_fn;
    logic              md_neg_q, md_neg_r, md_dbz;

    logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_y, jalr_sum, ex_result;
    logic [SH_W-1:0]   shamt;
    logic              eq, lt, ltu, taken;

    // Register numbers are consumed by the hazard unit, not here.
    logic unused_ok;
    assign unused_ok = ^{rs1_num, rs2_num};

    always_comb begin
        case (fwd1_sel)
            2'd1:    src_a = wb_data;
            2'd2:    src_a = mem_data;
            default: src_a = rs1;
        endcase
        case (fwd2_sel)
            2'd1:    fwd_b = wb_data;
            2'd2:    fwd_b = mem_data;
            default: fwd_b = rs2;
        endcase
    end

    assign src_b = alu_src ? imm : fwd_b;
    assign shamt = src_b[SH_W-1:0];

    always_comb begin
        alu_y = '0;
        case (alu_ctrl)
            4'd0:    alu_y = src_a + src_b;
            4'd1:    alu_y = src_a - src_b;
            4'd2:    alu_y = src_a & src_b;
            4'd3:    alu_y = src_a | src_b;
            4'd4:    alu_y = src_a ^ src_b;
            4'd5:    alu_y = {{(XLEN-1){1'b0}}, lt};
            4'd6:    alu_y = {{(XLEN-1){1'b0}}, ltu};
            4'd7:    alu_y = src_a << shamt;
            4'd8:    alu_y = src_a >> shamt;
            4'd9:    alu_y = $unsigned($signed(src_a) >>> shamt);
            4'd10:   alu_y = src_b;
            default: alu_y = '0;
        endcase
    end

    assign eq  = (src_a == src_b);
    assign lt  = ($signed(src_a) < $signed(src_b));
    assign ltu = (src_a < src_b);

    always_comb begin
        case (br_funct)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + imm;
    assign pc_target = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
    assign pc_src    = in_valid & ~stall & (jump | (branch & taken));

    // Operand sign handling: the iterative core works on magnitudes.
    logic a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_signed = (md_funct == 3'd1) | (md_funct == 3'd2) | (md_funct == 3'd4) | (md_funct == 3'd6);
    assign b_signed = (md_funct == 3'd1) | (md_funct == 3'd4) | (md_funct == 3'd6);
    assign a_neg    = a_signed & src_a[XLEN-1];
    assign b_neg    = b_signed & fwd_b[XLEN-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -fwd_b : fwd_b;

    logic md_fast, md_iter, issue;
    logic [XLEN-1:0] fast_res;
`ifdef EXEC_MD_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // Low 2*XLEN bits of the product of sign-extended operands equal the exact product.
    assign fast_prod = {{XLEN{a_neg}}, src_a} * {{XLEN{b_neg}}, fwd_b};
    assign fast_res  = (md_funct == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    assign md_fast   = md_op & ~md_funct[2];
`else
    assign fast_res  = '0;
    assign md_fast   = 1'b0;
`endif
    assign md_iter = md_op & ~md_fast;
    assign issue   = (state == S_IDLE) & in_valid & md_iter;
    assign stall   = issue | (state == S_BUSY);

    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md_opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff = div_sh - {1'b0, md_opnd};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, md_res;
    assign prod = md_neg_q ? -acc : acc;
    assign quo  = md_neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem  = md_neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        md_res = '0;
        case (md_fn)
            3'd0:       md_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_res = md_dbz ? '1 : quo;
            default:    md_res = md_dbz ? md_dividend : rem;
        endcase
    end

    always_comb begin
        ex_result = alu_y;
        if (md_op)
            ex_result = md_fast ? fast_res : md_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            acc         <= '0;
            md_opnd     <= '0;
            md_dividend <= '0;
            md_fn       <= '0;
            md_neg_q    <= 1'b0;
            md_neg_r    <= 1'b0;
            md_dbz      <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: if (issue) begin
                    state       <= S_BUSY;
                    count       <= CNT_W'(XLEN);
                    md_fn       <= md_funct;
                    md_neg_q    <= a_neg ^ b_neg;
                    md_neg_r    <= a_neg;
                    md_dbz      <= (fwd_b == '0);
                    md_dividend <= src_a;
                    // Divide: acc holds {remainder, quotient}; multiply: {product_hi, multiplier}.
                    if (md_funct[2]) begin
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        md_opnd <= b_mag;
                    end else begin
                        acc     <= {{XLEN{1'b0}}, b_mag};
                        md_opnd <= a_mag;
                    end
                end
                S_BUSY: begin
                    acc   <= md_fn[2] ? div_next : mul_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: if (en & in_valid & md_op)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || (en && stall)) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_result_src <= '0;
            out_result     <= '0;
            out_write_data <= '0;
            out_pc         <= '0;
            out_pc_plus_4  <= '0;
            out_rd_num     <= '0;
        end else if (en) begin
            out_valid      <= in_valid;
            out_reg_write  <= reg_write;
            out_mem_write  <= mem_write;
            out_mem_read   <= mem_read;
            out_result_src <= result_src;
            out_result     <= ex_result;
            out_write_data <= fwd_b;
            out_pc         <= pc;
            out_pc_plus_4  <= pc_plus_4;
            out_rd_num     <= rd_num;
        end
    end
endmodule

// File: tb/tb_exec_stage_md.sv
// Directed bench for exec_stage_md: expected results queued at issue, popped when EX/MEM loads.
module tb_exec_stage_md;
    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid;
    logic [31:0] pc, pc_plus_4, rs1, rs2, imm, mem_data, wb_data;
    logic [4:0]  rs1_num, rs2_num, rd_num;
    logic [1:0]  fwd1_sel, fwd2_sel, result_src;
    logic        alu_src, md_op, branch, jump, jalr, reg_write, mem_write, mem_read;
    logic [3:0]  alu_ctrl;
    logic [2:0]  md_funct, br_funct;
    logic        stall, pc_src, out_valid, out_reg_write, out_mem_write, out_mem_read;
    logic [31:0] pc_target, out_result, out_write_data, out_pc, out_pc_plus_4;
    logic [1:0]  out_result_src;
    logic [4:0]  out_rd_num;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    exec_stage_md dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .pc(pc), .pc_plus_4(pc_plus_4), .rs1(rs1), .rs2(rs2), .imm(imm),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .mem_data(mem_data), .wb_data(wb_data),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .md_op(md_op), .md_funct(md_funct),
        .branch(branch), .jump(jump), .jalr(jalr), .br_funct(br_funct),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read), .result_src(result_src),
        .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .out_result_src(out_result_src), .out_result(out_result),
        .out_write_data(out_write_data), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4),
        .out_rd_num(out_rd_num)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << s;
            4'd8:  return a >> s;
            4'd9:  return $unsigned($signed(a) >>> s);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : $unsigned($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int md_stall_exp(input logic [2:0] f);
`ifdef EXEC_MD_FAST_MUL_EN
        return f[2] ? 33 : 0;
`else
        return (f == f) ? 33 : 33;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (exp_q.size() == 0)
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else begin
            e = exp_q.pop_front();
            chk(tag, out_result, e);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; md_op = 0; branch = 0; jump = 0; jalr = 0;
        fwd1_sel = 0; fwd2_sel = 0; alu_src = 0; flush = 0; en = 1;
    endtask

    task automatic do_alu(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic use_imm);
        in_valid = 1; md_op = 0; alu_ctrl = c; rs1 = a; fwd1_sel = 0; fwd2_sel = 0;
        alu_src = use_imm;
        if (use_imm) begin imm = b; rs2 = 32'h5A5A_5A5A; end
        else rs2 = b;
        exp_q.push_back(alu_ref(c, a, b));
        #1;
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check_out(tag);
    endtask

    task automatic run_md(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic bub_ok;
        in_valid = 1; md_op = 1; md_funct = f; rs1 = a; rs2 = b;
        fwd1_sel = 0; fwd2_sel = 0; alu_src = 0; en = 1; reg_write = 1;
        exp_q.push_back(md_ref(f, a, b));
        n = 0; bub_ok = 1;
        #1;
        while (stall === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bub_ok = 0;
            rs1 = $urandom; rs2 = $urandom;
            n++;
        end
        rs1 = a; rs2 = b;
        chk({tag, "_stall_cycles"}, n, md_stall_exp(f));
        chk({tag, "_bubbles"}, {31'b0, bub_ok}, 32'd1);
        @(posedge clk); #1;
        in_valid = 0; md_op = 0;
        check_out(tag);
    endtask

    task automatic abort_mid_busy(input string tag, input logic use_reset);
        in_valid = 1; md_op = 1; md_funct = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
        fwd1_sel = 0; fwd2_sel = 0; alu_src = 0; en = 1;
        @(posedge clk); #1;
        repeat (22) @(posedge clk);
        #1;
        chk({tag, "_busy_before"}, {31'b0, stall}, 32'd1);
        if (use_reset) reset = 1; else flush = 1;
        in_valid = 0; md_op = 0;
        @(posedge clk); #1;
        reset = 0; flush = 0;
        chk({tag, "_stall_after"}, {31'b0, stall}, 32'd0);
        chk({tag, "_out_zero"}, {31'b0, |{out_valid, out_reg_write, out_mem_write, out_mem_read,
            out_result_src, out_result, out_write_data, out_pc, out_pc_plus_4, out_rd_num}}, 32'd0);
        run_md({tag, "_reissue"}, 3'd4, 32'd1000, 32'd3);
    endtask

    initial begin
        logic [31:0] held;
        idle_inputs();
        reset = 1; pc = 32'h40; pc_plus_4 = 32'h44; rs1 = 0; rs2 = 0; imm = 0;
        mem_data = 0; wb_data = 0; rs1_num = 5'd1; rs2_num = 5'd2; rd_num = 5'd0;
        alu_ctrl = 0; md_funct = 0; br_funct = 0; reg_write = 0; mem_write = 0;
        mem_read = 0; result_src = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_zero", {31'b0, |{out_valid, out_reg_write, out_mem_write, out_mem_read,
            out_result_src, out_result, out_write_data, out_pc, out_pc_plus_4, out_rd_num}}, 32'd0);
        reset = 0;
        #1;
        chk("reset_stall", {31'b0, stall}, 32'd0);

        // ADD with SrcA forwarded from MEM
        in_valid = 1; alu_ctrl = 4'd0; fwd1_sel = 2; mem_data = 32'd7; rs1 = 32'd99;
        rs2 = 32'hFFFF_FFFD; rd_num = 5'd9; reg_write = 1; result_src = 2'd1;
        exp_q.push_back(32'd4);
        #1;
        chk("add_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check_out("add_fwd");
        chk("add_write_data", out_write_data, 32'hFFFF_FFFD);
        chk("add_rd_num", {27'b0, out_rd_num}, 32'd9);
        chk("add_result_src", {30'b0, out_result_src}, 32'd1);

        do_alu("sub",   4'd1,  32'd5,          32'd9,          1'b0);
        do_alu("and",   4'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  1'b1);
        do_alu("or",    4'd3,  32'h1200_0000,  32'h0000_0034,  1'b0);
        do_alu("xor",   4'd4,  32'hFFFF_0000,  32'h0F0F_0F0F,  1'b0);
        do_alu("slt",   4'd5,  32'hFFFF_FFFE,  32'd1,          1'b0);
        do_alu("sltu",  4'd6,  32'hFFFF_FFFE,  32'd1,          1'b0);
        do_alu("sll",   4'd7,  32'h0000_0003,  32'h0000_0024,  1'b1);
        do_alu("srl",   4'd8,  32'h8000_0000,  32'd31,         1'b0);
        do_alu("sra",   4'd9,  32'h8000_0000,  32'd4,          1'b0);
        do_alu("passb", 4'd10, 32'd1,          32'hCAFE_0001,  1'b1);

        // rs2 forwarded from WB
        in_valid = 1; alu_ctrl = 4'd0; fwd1_sel = 0; rs1 = 32'd10; fwd2_sel = 1;
        wb_data = 32'd32; rs2 = 32'd1; alu_src = 0;
        exp_q.push_back(32'd42);
        @(posedge clk); #1;
        check_out("add_fwd_wb");
        held = 32'd42;

        // en=0 holds EX/MEM
        en = 0; fwd2_sel = 0; rs2 = 32'd100;
        @(posedge clk); #1;
        chk("en0_hold", out_result, held);
        en = 1;
        idle_inputs();

        // Branch / jump resolution
        in_valid = 1; branch = 1; br_funct = 3'b000; pc = 32'h100; imm = 32'h20;
        rs1 = 32'd5; rs2 = 32'd5;
        #1;
        chk("beq_pc_src", {31'b0, pc_src}, 32'd1);
        chk("beq_target", pc_target, 32'h120);
        br_funct = 3'b001;
        #1;
        chk("bne_pc_src", {31'b0, pc_src}, 32'd0);
        br_funct = 3'b100; rs1 = 32'hFFFF_FFF0;
        #1;
        chk("blt_pc_src", {31'b0, pc_src}, 32'd1);
        branch = 0; jump = 1; jalr = 1; rs1 = 32'h203; imm = 32'd4;
        #1;
        chk("jalr_pc_src", {31'b0, pc_src}, 32'd1);
        chk("jalr_target", pc_target, 32'h206);
        idle_inputs();
        @(posedge clk); #1;

        run_md("divu",     3'd5, 32'd100,         32'd7);
        run_md("div_ovf",  3'd4, 32'h8000_0000,   32'hFFFF_FFFF);
        run_md("rem_dbz",  3'd6, 32'hDEAD_BEEF,   32'd0);
        run_md("divu_dbz", 3'd5, 32'd5,           32'd0);
        run_md("div_neg",  3'd4, 32'hFFFF_FFF9,   32'd2);
        run_md("rem_neg",  3'd6, 32'hFFFF_FFF9,   32'd2);
        run_md("remu",     3'd7, 32'd1000,        32'd7);
        run_md("mulh",     3'd1, 32'hFFFF_FFFE,   32'd3);
        run_md("mulhu",    3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF);
        run_md("mulhsu",   3'd2, 32'hFFFF_FFFE,   32'hFFFF_FFFF);
        run_md("mul",      3'd0, 32'h1234_5678,   32'h9ABC_DEF1);

        abort_mid_busy("flush", 1'b0);
        abort_mid_busy("reset", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
